// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM link: splits a strobed slot stream into four
// parallel channels, locking on a slot-0 sync marker and flagging framing errors.
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         sync,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         frame_valid,
  output logic         sync_err
);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_slot;
  logic [1:0]        w_slot_nxt;
  // Only slots 0..2 need holding; slot 3 goes straight from din to q3.
  logic [2:0][W-1:0] r_shadow;
  logic [2:0][W-1:0] w_shadow_nxt;
  logic [3:0][W-1:0] r_q;
  logic [3:0][W-1:0] w_q_nxt;
  logic              r_frame_valid;
  logic              w_frame_valid_nxt;
  logic              r_sync_err;
  logic              w_sync_err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HUNT;
      r_slot        <= 2'd0;
      r_shadow      <= '0;
      r_q           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_slot        <= w_slot_nxt;
      r_shadow      <= w_shadow_nxt;
      r_q           <= w_q_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_sync_err    <= w_sync_err_nxt;
    end
  end

  // en is a plain strobe, not a handshake: each en=1 edge consumes exactly
  // one slot of din/sync and there is no backpressure toward the sender.
  always_comb begin
    w_state_nxt       = r_state;
    w_slot_nxt        = r_slot;
    w_shadow_nxt      = r_shadow;
    w_q_nxt           = r_q;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = r_sync_err;
    if (en) begin
      unique case (r_state)
        S_HUNT: begin
          if (sync) begin
            w_shadow_nxt[0] = din;
            w_slot_nxt      = 2'd1;
            w_state_nxt     = S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (sync) begin
            // Early sync restarts the frame; the partial one is simply overwritten.
            if (r_slot != 2'd0) w_sync_err_nxt = 1'b1;
            w_shadow_nxt[0] = din;
            w_slot_nxt      = 2'd1;
          end else if (r_slot == 2'd0) begin
            w_sync_err_nxt = 1'b1;
            w_slot_nxt     = 2'd0;
            w_state_nxt    = S_HUNT;
          end else if (r_slot == 2'd3) begin
            w_q_nxt           = {din, r_shadow[2], r_shadow[1], r_shadow[0]};
            w_frame_valid_nxt = 1'b1;
            w_slot_nxt        = 2'd0;
          end else begin
            w_shadow_nxt[r_slot] = din;
            w_slot_nxt           = r_slot + 2'd1;
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  assign q0          = r_q[0];
  assign q1          = r_q[1];
  assign q2          = r_q[2];
  assign q3          = r_q[3];
  assign slot        = r_slot;
  assign locked      = (r_state == S_LOCKED);
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: a W=4 and a W=1 instance share one stimulus stream and
// are checked against a queue-based frame model.
module tb_tdm_demux4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sync;
  logic [W-1:0] din;
  logic [W-1:0] q0, q1, q2, q3;
  logic [1:0]   slot;
  logic         locked, frame_valid, sync_err;
  logic         a_q0, a_q1, a_q2, a_q3;
  logic [1:0]   a_slot;
  logic         a_locked, a_frame_valid, a_sync_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is the list of slots collected since the last sync.
  logic         m_locked;
  logic [W-1:0] m_frame[$];
  logic [W-1:0] m_q[4];
  logic         m_fv;
  logic         m_err;

  always #5 clk = ~clk;

  tdm_demux4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3), .slot(slot), .locked(locked),
    .frame_valid(frame_valid), .sync_err(sync_err)
  );

  tdm_demux4 #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din[0]), .sync(sync),
    .q0(a_q0), .q1(a_q1), .q2(a_q2), .q3(a_q3), .slot(a_slot), .locked(a_locked),
    .frame_valid(a_frame_valid), .sync_err(a_sync_err)
  );

  task automatic model_reset();
    m_locked = 1'b0;
    m_frame.delete();
    for (int i = 0; i < 4; i++) m_q[i] = '0;
    m_fv  = 1'b0;
    m_err = 1'b0;
  endtask

  // Drive one clock of stimulus, advance the model on the edge, return at edge+1.
  task automatic apply(input logic e, input logic s, input logic [W-1:0] d);
    @(negedge clk);
    en = e; sync = s; din = d;
    @(posedge clk);
    m_fv = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_frame.delete();
          m_frame.push_back(d);
          m_locked = 1'b1;
        end
      end else if (s) begin
        if (m_frame.size() != 0) m_err = 1'b1;
        m_frame.delete();
        m_frame.push_back(d);
      end else if (m_frame.size() == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_frame.push_back(d);
        if (m_frame.size() == 4) begin
          for (int i = 0; i < 4; i++) m_q[i] = m_frame[i];
          m_fv = 1'b1;
          m_frame.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; sync = 1'b1; din = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_vec++; if ({q0, q1, q2, q3} !== 16'h0) begin n_err++; $display("FAIL reset_q: got %h exp 0", {q0, q1, q2, q3}); end
    n_vec++; if (slot !== 2'd0) begin n_err++; $display("FAIL reset_slot: got %0d exp 0", slot); end
    n_vec++; if ({locked, frame_valid, sync_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b exp 000", {locked, frame_valid, sync_err}); end
    n_vec++; if ({a_q0, a_q1, a_q2, a_q3, a_slot, a_locked, a_frame_valid, a_sync_err} !== 9'h0) begin
      n_err++; $display("FAIL reset_w1: got %b exp 0", {a_q0, a_q1, a_q2, a_q3, a_slot, a_locked, a_frame_valid, a_sync_err});
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_hunt();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, W'($urandom));
      n_vec++; if ({slot, locked, frame_valid} !== 4'b0000) begin n_err++; $display("FAIL hunt_%0d: got slot=%0d locked=%b fv=%b exp 0/0/0", i, slot, locked, frame_valid); end
    end
  endtask

  task automatic test_basic();
    logic [3:0] pat;
    pat = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, i == 0, {3'b000, pat[i]});
      n_vec++; if (frame_valid !== (i == 3)) begin n_err++; $display("FAIL basic_fv_%0d: got %b exp %b", i, frame_valid, i == 3); end
    end
    n_vec++; if ({q0, q1, q2, q3} !== 16'h1011) begin n_err++; $display("FAIL basic_q: got %h exp 1011", {q0, q1, q2, q3}); end
    n_vec++; if ({a_q0, a_q1, a_q2, a_q3} !== 4'b1011) begin n_err++; $display("FAIL basic_q_w1: got %b exp 1011", {a_q0, a_q1, a_q2, a_q3}); end
    n_vec++; if ({locked, sync_err, a_locked, a_sync_err} !== 4'b1010) begin n_err++; $display("FAIL basic_flags: got %b exp 1010", {locked, sync_err, a_locked, a_sync_err}); end
    apply(1'b0, 1'b0, 4'h0);
    n_vec++; if ({frame_valid, a_frame_valid} !== 2'b00) begin n_err++; $display("FAIL basic_fv_drop: got %b exp 00", {frame_valid, a_frame_valid}); end
  endtask

  task automatic test_en_gaps();
    logic [3:0] fr[8];
    fr = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, (i % 4) == 0, fr[i]);
      n_vec++; if (frame_valid !== ((i % 4) == 3)) begin n_err++; $display("FAIL gaps_fv_%0d: got %b exp %b", i, frame_valid, (i % 4) == 3); end
      apply(1'b0, 1'($urandom), W'($urandom));
      n_vec++; if ({slot, frame_valid} !== {2'((i + 1) % 4), 1'b0}) begin n_err++; $display("FAIL gaps_idle_%0d: got slot=%0d fv=%b exp slot=%0d fv=0", i, slot, frame_valid, (i + 1) % 4); end
      if (i == 3) begin
        n_vec++; if ({q0, q1, q2, q3} !== 16'hABCD) begin n_err++; $display("FAIL gaps_q1: got %h exp abcd", {q0, q1, q2, q3}); end
      end
    end
    n_vec++; if ({q0, q1, q2, q3} !== 16'h1234) begin n_err++; $display("FAIL gaps_q2: got %h exp 1234", {q0, q1, q2, q3}); end
  endtask

  task automatic test_early_sync();
    apply(1'b1, 1'b1, 4'h5);
    apply(1'b1, 1'b0, 4'h6);
    apply(1'b1, 1'b1, 4'h7);
    n_vec++; if ({sync_err, frame_valid, slot, locked} !== 5'b10011) begin n_err++; $display("FAIL early_flags: got err=%b fv=%b slot=%0d locked=%b exp 1/0/1/1", sync_err, frame_valid, slot, locked); end
    apply(1'b1, 1'b0, 4'h8);
    apply(1'b1, 1'b0, 4'h9);
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL early_no_fv: got %b exp 0", frame_valid); end
    apply(1'b1, 1'b0, 4'hA);
    n_vec++; if ({frame_valid, q0, q1, q2, q3} !== {1'b1, 16'h789A}) begin n_err++; $display("FAIL early_q: got fv=%b q=%h exp 1/789a", frame_valid, {q0, q1, q2, q3}); end
  endtask

  task automatic test_missing_sync();
    apply(1'b1, 1'b0, 4'h1);
    n_vec++; if ({sync_err, locked, slot} !== 4'b1000) begin n_err++; $display("FAIL miss_flags: got err=%b locked=%b slot=%0d exp 1/0/0", sync_err, locked, slot); end
    n_vec++; if ({q0, q1, q2, q3} !== 16'h789A) begin n_err++; $display("FAIL miss_hold: got %h exp 789a", {q0, q1, q2, q3}); end
    apply(1'b1, 1'b1, 4'h3);
    n_vec++; if ({locked, slot} !== 3'b101) begin n_err++; $display("FAIL miss_relock: got locked=%b slot=%0d exp 1/1", locked, slot); end
  endtask

  task automatic test_async_reset();
    apply(1'b1, 1'b0, 4'h4);
    apply(1'b1, 1'b0, 4'h5);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++; if ({q0, q1, q2, q3, slot, locked, frame_valid, sync_err} !== 21'h0) begin
      n_err++; $display("FAIL async_rst: got q=%h slot=%0d locked=%b fv=%b err=%b exp all 0", {q0, q1, q2, q3}, slot, locked, frame_valid, sync_err);
    end
    n_vec++; if ({a_q0, a_q1, a_q2, a_q3, a_slot, a_locked, a_sync_err} !== 8'h0) begin n_err++; $display("FAIL async_rst_w1: got nonzero exp 0"); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 1'b0, W'($urandom));
      n_vec++; if ({locked, q0, q1, q2, q3} !== 17'h0) begin n_err++; $display("FAIL post_rst_%0d: got locked=%b q=%h exp 0/0", i, locked, {q0, q1, q2, q3}); end
    end
  endtask

  task automatic test_random();
    logic e, s, s_ok;
    for (int i = 0; i < 400; i++) begin
      e    = ($urandom_range(0, 3) != 0);
      s_ok = (m_frame.size() == 0);
      s    = ($urandom_range(0, 11) == 0) ? !s_ok : s_ok;
      apply(e, s, W'($urandom));
      n_vec++; if ({q0, q1, q2, q3} !== {m_q[0], m_q[1], m_q[2], m_q[3]}) begin
        n_err++; $display("FAIL rand_q_%0d: got %h exp %h", i, {q0, q1, q2, q3}, {m_q[0], m_q[1], m_q[2], m_q[3]});
      end
      n_vec++; if ({slot, locked, frame_valid, sync_err} !== {2'(m_frame.size()), m_locked, m_fv, m_err}) begin
        n_err++; $display("FAIL rand_ctl_%0d: got %b exp %b", i, {slot, locked, frame_valid, sync_err}, {2'(m_frame.size()), m_locked, m_fv, m_err});
      end
      n_vec++; if ({a_q0, a_q1, a_q2, a_q3, a_slot, a_locked, a_frame_valid, a_sync_err} !==
                   {m_q[0][0], m_q[1][0], m_q[2][0], m_q[3][0], 2'(m_frame.size()), m_locked, m_fv, m_err}) begin
        n_err++; $display("FAIL rand_w1_%0d: got %b", i, {a_q0, a_q1, a_q2, a_q3, a_slot, a_locked, a_frame_valid, a_sync_err});
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
    model_reset();
    test_reset();
    test_hunt();
    test_basic();
    test_en_gaps();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 1, bit width of one time slot (and of each output channel).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  slot strobe; din/sync sampled only on clk edges with en=1.
REQ-005 Port: din  input  W  serial TDM data, one slot per en strobe, slot order 0,1,2,3.
REQ-006 Port: sync  input  1  frame marker, required high on the slot-0 strobe only.
REQ-007 Port: q0,q1,q2,q3  output  W each  last complete frame, channels 0..3.
REQ-008 Port: slot  output  2  index of the slot the next strobe will capture ({S1,S0}).
REQ-009 Port: locked  output  1  high while in LOCKED state.
REQ-010 Port: frame_valid  output  1  one-cycle pulse when q0..q3 update.
REQ-011 Port: sync_err  output  1  sticky framing-error flag.

Function
REQ-012 Block is the receive end of a 4:1 TDM link: recovers four channels from one slot stream.
REQ-013 States: HUNT, LOCKED; all outputs registered.
REQ-014 HUNT, en=1, sync=1: capture din into shadow[0], slot<=1, go LOCKED.
REQ-015 HUNT, en=1, sync=0: discard din, stay in HUNT, slot stays 0.
REQ-016 LOCKED, en=1, sync=0, slot in 1..3: capture din into shadow[slot], slot<=slot+1 (3 wraps to 0).
REQ-017 On the slot-3 capture: q0..q2<=shadow[0..2], q3<=din, frame_valid<=1, all on the same edge; one-edge latency from last slot to outputs.
REQ-018 frame_valid SHALL be 0 on every other edge; never high two consecutive cycles unless consecutive strobes complete frames (impossible: minimum 4 strobes per frame).
REQ-019 LOCKED, en=1, sync=1, slot=0: normal frame start: capture shadow[0], slot<=1.
REQ-020 LOCKED, en=1, sync=1, slot!=0 (early sync): sync_err<=1, partial shadow discarded, din captured as new shadow[0], slot<=1, stay LOCKED.
REQ-021 LOCKED, en=1, sync=0, slot=0 (missing sync): sync_err<=1, din discarded, go HUNT, slot<=0.
REQ-022 en=0: no state, slot, shadow or q change; frame_valid<=0; din/sync ignored.
REQ-023 q0..q3 change only per REQ-017; aborted frames never reach outputs; q holds last good frame indefinitely.
REQ-024 sync_err once set stays 1 until rst; errors never block subsequent frame recovery.
REQ-025 locked=1 exactly when state is LOCKED.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously) force: state HUNT, slot=0, shadow=0, q0..q3=0, frame_valid=0, locked=0, sync_err=0.
REQ-027 rst asserted mid-frame discards the partial frame; first frame after release requires a new sync.
REQ-028 After rst deasserts, block is in HUNT; first edge with en=1 and sync=1 is slot 0.

Verification
REQ-029 W=1, en=1 continuously, sync on slot 0, din=1,0,1,1 -> edge after slot 3: q0..q3=1,0,1,1, frame_valid one cycle, locked=1, sync_err=0.
REQ-030 W=4, frames {A,B,C,D} then {1,2,3,4} with en toggling every other cycle -> q=A,B,C,D after frame 1 then 1,2,3,4; slot advances only on en cycles.
REQ-031 Locked, sync asserted on slot 2 with din=7 (W=4), then slots 8,9,A -> sync_err=1, no frame_valid for the aborted frame, next q=7,8,9,A.
REQ-032 Locked, sync=0 on slot-0 strobe -> sync_err=1, locked=0, slot=0; q holds previous frame; next sync relocks.
REQ-033 rst pulsed after slot 2 (not aligned to clk) -> all outputs 0 immediately; stream continuing without sync keeps locked=0 and q=0.
REQ-034 HUNT with en=1, sync=0 for 10 cycles -> slot=0, locked=0, frame_valid never asserted.
